loop_seq: RTL and testbench
===========================

// Module: loop_seq
// PURPOSE
//  Parametrised program sequencer with a hardware zero-overhead loop stack; successor to prog_seq.
//  Drives the instruction-memory address each cycle and applies nested loop-back without jump instructions.
//  Adds a stall enable, absolute jumps, stack flush, zero-trip skip and correct handling of shared loop ends.
//  Also adds overflow detection. Sits between the instruction decoder and the program ROM address port.
// PARAMETERS
//  ADDR_W     16  program-address width; all address arithmetic is modulo 2**ADDR_W
//  DEPTH      4   loop-stack entries (max nesting), >=1
//  ITER_W     8   width of trip count
//  SIZE_W     8   width of loop-body length
//  RESET_ADDR 0   address driven after reset
// PORTS
//  clk        in   1        clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  en         in   1        advance; 0 = hold addr and all state, ignore other inputs
//  loop_we    in   1        current addr holds a LOOP instruction; push loop
//  loop_iter  in   ITER_W   total body executions N (sampled with loop_we)
//  loop_size  in   SIZE_W   body length S; body occupies addr+1 .. addr+S
//  jump       in   1        load jump_addr next cycle
//  jump_addr  in   ADDR_W   jump target
//  stack_clr  in   1        discard all loop entries
//  addr       out  ADDR_W   registered program address
//  depth      out  clog2(DEPTH+1)  number of active loop entries
//  loop_active out 1        depth != 0
//  ovf_err    out  1        sticky: push attempted with stack full
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): addr=RESET_ADDR, depth=0, ovf_err=0; entry contents don't-care.
//  - All updates on rising clk when en=1. Priority: stack_clr > jump > loop_we > loop-end check > addr+1.
//  - stack_clr: depth<=0. In the same cycle, addr<=jump_addr if jump=1, else addr+1. loop_we is ignored.
//  - jump: addr<=jump_addr; stack untouched; loop_we ignored in that cycle.
//  - loop_we at address A, N>=1, S>=1, depth<DEPTH: push {start=A+1, end=A+S, rem=N-1}, addr<=A+1.
//  - loop_we with N==0 or S==0: no push; addr<=A+S+1 (body skipped).
//  - loop_we with depth==DEPTH: no push; ovf_err<=1; addr<=A+1 (body runs once).
//  - Loop-end check (no jump/loop_we/clr), scanning from top entry downward:
//     * If the top entry has end!=addr: addr<=addr+1.
//     * If an entry has end==addr and rem!=0: rem<=rem-1, addr<=start. Every exhausted entry above it is popped.
//     * If an entry has end==addr and rem==0: it is popped and the scan continues to the next lower entry.
//     * The scan stops at the first entry whose end!=addr, or at empty; then addr<=addr+1.
//     * All pops and the loop-back resolve in one cycle, so nested loops sharing an end address cost 0 cycles.
//  - Loop-back costs 0 cycles: with N=3, S=2 the body runs exactly 3 times, back-to-back.
//  - Wrap: A+S and addr+1 wrap modulo 2**ADDR_W; end comparisons are on wrapped values.
//  - en=0 mid-loop freezes rem/addr/depth; resumes identically.
//  - reset_n low mid-loop: immediate return to reset state.
//  - ovf_err clears only on reset. depth/loop_active are registered state, not a combinational decode of inputs.
// STRUCTURE
//  - Shared package prog_seq_pkg holds:
//     * loop_entry_t struct {start[ADDR_W], end_addr[ADDR_W], rem[ITER_W]}
//     * depth-width helper function
//     * next-addr select encoding (INC, LOOPBACK, SKIP, JUMP)
//  - Sub-module loop_stack: DEPTH entries, push/pop-k/decrement-top, exposes all entries for the scan.
//    It is reused by future multi-context sequencers.
//  - loop_seq keeps the addr register, the priority mux, the end-match scan and the error flag.
// TESTING
//  1. Reset with reset_n=0 mid-run, then release -> addr=0, depth=0, ovf_err=0; addr counts 0,1,2,...
//  2. At A=2, loop_we with N=3, S=2 -> addr sequence 3,4,3,4,3,4,5; depth 1 during body, 0 at addr 5.
//  3. Nested shared end: outer at 0 (N=2,S=4), inner at 1 (N=2,S=3), both ending at 4
//     -> addr 1,2,3,4,2,3,4,1,2,3,4,2,3,4,5.
//  4. Zero trip: at A=10, N=0, S=5 -> next addr 16, depth unchanged. Same result for N=4, S=0 -> next addr 11.
//  5. Overflow with DEPTH=4: push 5 nested loops -> 5th ignored, ovf_err=1 and stays 1, depth=4.
//     The outer loops still iterate correctly.
//  6. Stall and jump: en=0 for 3 cycles inside a loop -> addr held, rem intact.
//     jump=1, jump_addr=0xFFFF, stack_clr=1 -> addr=0xFFFF, depth=0; next addr wraps to 0x0000.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program-sequencer family (prog_seq, loop_seq and
// future multi-context sequencers).
//   SEQ_ADDR_W / SEQ_ITER_W : field widths of a loop-stack entry
//   loop_entry_t            : one hardware loop {start, end_addr, rem}
//   depth_w()               : width of a counter holding 0..depth
//   addr_sel_e              : next-address source selection
package prog_seq_pkg;

    // The entry type is fixed-width; the sequencer ADDR_W/ITER_W parameters
    // must equal these.
    localparam int unsigned SEQ_ADDR_W = 16;
    localparam int unsigned SEQ_ITER_W = 8;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] start;
        logic [SEQ_ADDR_W-1:0] end_addr;
        logic [SEQ_ITER_W-1:0] rem;
    } loop_entry_t;

    function automatic int unsigned depth_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        SEL_INC,
        SEL_LOOPBACK,
        SEL_SKIP,
        SEL_JUMP
    } addr_sel_e;

endpackage

// File: rtl/loop_stack.sv
// Hardware loop stack: DEPTH entries with push, pop-k, decrement of the entry
// that becomes top after the pop, and flush. All entries are exposed so the
// owner can scan them combinationally.
//   clk, reset_n : clock, asynchronous active-low reset (count only)
//   clr          : discard all entries (highest priority)
//   push         : append push_entry (caller guarantees count < DEPTH)
//   pop_cnt      : number of entries to pop when neither clr nor push
//   dec          : decrement rem of the new top after popping pop_cnt
//   entries      : entry storage, index 0 is the bottom
//   count        : number of valid entries
module loop_stack
    import prog_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = depth_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              push,
    input  loop_entry_t       push_entry,
    input  logic [CNT_W-1:0]  pop_cnt,
    input  logic              dec,
    output loop_entry_t       entries [DEPTH],
    output logic [CNT_W-1:0]  count
);

    loop_entry_t      ent_q [DEPTH];
    loop_entry_t      ent_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(count_q) == i) begin
                    ent_d[i] = push_entry;
                end
            end
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q - pop_cnt;
            if (dec) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (32'(count_d) == i + 1) begin
                        ent_d[i].rem = ent_q[i].rem - SEQ_ITER_W'(1);
                    end
                end
            end
        end
    end

    // Entry contents are don't-care after reset; only the count is reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign entries = ent_q;
    assign count   = count_q;

endmodule

// File: rtl/loop_seq.sv
// Program sequencer with zero-overhead nested hardware loops. Drives the
// instruction-memory address every cycle and applies loop-back, zero-trip
// skip, absolute jumps and stack flush.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance; 0 holds addr and all state
//   loop_we      : current addr holds a LOOP instruction
//   loop_iter    : total body executions N
//   loop_size    : body length S (body at addr+1 .. addr+S)
//   jump         : load jump_addr
//   jump_addr    : jump target
//   stack_clr    : discard all loop entries
//   addr         : registered program address
//   depth        : number of active loop entries
//   loop_active  : depth != 0
//   ovf_err      : sticky, push attempted with stack full
module loop_seq
    import prog_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W     = SEQ_ADDR_W,
    parameter int unsigned        DEPTH      = 4,
    parameter int unsigned        ITER_W     = SEQ_ITER_W,
    parameter int unsigned        SIZE_W     = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        loop_we,
    input  logic [ITER_W-1:0]           loop_iter,
    input  logic [SIZE_W-1:0]           loop_size,
    input  logic                        jump,
    input  logic [ADDR_W-1:0]           jump_addr,
    input  logic                        stack_clr,
    output logic [ADDR_W-1:0]           addr,
    output logic [depth_w(DEPTH)-1:0]   depth,
    output logic                        loop_active,
    output logic                        ovf_err
);

    localparam int unsigned DW = depth_w(DEPTH);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              ovf_q;
    logic              ovf_d;

    loop_entry_t       entries [DEPTH];
    logic [DW-1:0]     stack_cnt;
    loop_entry_t       push_entry;
    logic              st_clr;
    logic              st_push;
    logic [DW-1:0]     st_pop;
    logic              st_dec;

    logic              loopback;
    logic [ADDR_W-1:0] lb_start;
    logic [DW-1:0]     scan_pops;
    logic              scan_done;
    addr_sel_e         addr_sel;

    loop_stack #(
        .DEPTH (DEPTH),
        .CNT_W (DW)
    ) u_stack (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (st_clr),
        .push       (st_push),
        .push_entry (push_entry),
        .pop_cnt    (st_pop),
        .dec        (st_dec),
        .entries    (entries),
        .count      (stack_cnt)
    );

    assign push_entry = '{
        start:    addr_q + ADDR_W'(1),
        end_addr: addr_q + ADDR_W'(loop_size),
        rem:      loop_iter - ITER_W'(1)
    };

    // End-match scan from the top entry downward: exhausted entries ending
    // here are counted for popping, the first live one ending here loops back.
    // Physical slots above the valid count are skipped, so iterating from the
    // highest slot visits the true top first.
    always_comb begin
        scan_done = 1'b0;
        loopback  = 1'b0;
        lb_start  = '0;
        scan_pops = '0;
        for (int unsigned n = 0; n < DEPTH; n++) begin
            if (!scan_done && (DEPTH - 1 - n) < 32'(stack_cnt)) begin
                if (entries[DEPTH-1-n].end_addr == addr_q) begin
                    if (entries[DEPTH-1-n].rem != '0) begin
                        loopback  = 1'b1;
                        lb_start  = entries[DEPTH-1-n].start;
                        scan_done = 1'b1;
                    end else begin
                        scan_pops = scan_pops + DW'(1);
                    end
                end else begin
                    scan_done = 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_sel = SEL_INC;
        st_clr   = 1'b0;
        st_push  = 1'b0;
        st_pop   = '0;
        st_dec   = 1'b0;
        ovf_d    = ovf_q;
        addr_d   = addr_q;
        if (en) begin
            if (stack_clr) begin
                st_clr   = 1'b1;
                addr_sel = jump ? SEL_JUMP : SEL_INC;
            end else if (jump) begin
                addr_sel = SEL_JUMP;
            end else if (loop_we) begin
                if (loop_iter == '0 || loop_size == '0) begin
                    addr_sel = SEL_SKIP;
                end else if (stack_cnt == DW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    st_push = 1'b1;
                end
            end else begin
                st_pop = scan_pops;
                st_dec = loopback;
                if (loopback) begin
                    addr_sel = SEL_LOOPBACK;
                end
            end

            unique case (addr_sel)
                SEL_INC:      addr_d = addr_q + ADDR_W'(1);
                SEL_LOOPBACK: addr_d = lb_start;
                SEL_SKIP:     addr_d = addr_q + ADDR_W'(loop_size) + ADDR_W'(1);
                SEL_JUMP:     addr_d = jump_addr;
                default:      addr_d = addr_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= RESET_ADDR;
            ovf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign addr        = addr_q;
    assign depth       = stack_cnt;
    assign loop_active = (stack_cnt != '0);
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_loop_seq.sv
// Scoreboard bench for loop_seq: the driver steps a queue-based reference
// model each cycle and pushes the expected post-edge outputs; an independent
// monitor pops and compares after every rising edge.
module tb_loop_seq;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        loop_we;
    logic [7:0]  loop_iter;
    logic [7:0]  loop_size;
    logic        jump;
    logic [15:0] jump_addr;
    logic        stack_clr;
    logic [15:0] addr;
    logic [2:0]  depth;
    logic        loop_active;
    logic        ovf_err;

    loop_seq #(
        .ADDR_W     (16),
        .DEPTH      (4),
        .ITER_W     (8),
        .SIZE_W     (8),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .loop_we     (loop_we),
        .loop_iter   (loop_iter),
        .loop_size   (loop_size),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .stack_clr   (stack_clr),
        .addr        (addr),
        .depth       (depth),
        .loop_active (loop_active),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a plain queue of open loops, top at the back.
    typedef struct {
        logic [15:0] st;
        logic [15:0] end_a;
        int          rem;
    } ment_t;

    typedef struct {
        logic [15:0] addr;
        int          depth;
        bit          ovf;
    } exp_t;

    ment_t       stk[$];
    logic [15:0] m_addr;
    bit          m_ovf;
    exp_t        sb_q[$];

    // Loop instructions of the directed "program": address -> {N, S}.
    int prog_n[int];
    int prog_s[int];

    task automatic model_step();
        bit    done;
        ment_t t;
        if (!en) return;
        if (stack_clr) begin
            stk.delete();
            m_addr = jump ? jump_addr : m_addr + 16'd1;
        end else if (jump) begin
            m_addr = jump_addr;
        end else if (loop_we) begin
            if (loop_iter == 0 || loop_size == 0) begin
                m_addr = m_addr + 16'(loop_size) + 16'd1;
            end else if (stk.size() == 4) begin
                m_ovf  = 1'b1;
                m_addr = m_addr + 16'd1;
            end else begin
                t.st    = m_addr + 16'd1;
                t.end_a = m_addr + 16'(loop_size);
                t.rem   = int'(loop_iter) - 1;
                stk.push_back(t);
                m_addr = m_addr + 16'd1;
            end
        end else begin
            done = 1'b0;
            while (!done && stk.size() > 0 && stk[stk.size()-1].end_a == m_addr) begin
                t = stk[stk.size()-1];
                if (t.rem > 0) begin
                    t.rem--;
                    stk[stk.size()-1] = t;
                    m_addr = t.st;
                    done   = 1'b1;
                end else begin
                    void'(stk.pop_back());
                end
            end
            if (!done) m_addr = m_addr + 16'd1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.addr  = m_addr;
        e.depth = stk.size();
        e.ovf   = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit e, input bit we, input int n, input int s,
                       input bit j, input int ja, input bit c);
        @(negedge clk);
        reset_n   = 1'b1;
        en        = e;
        loop_we   = we;
        loop_iter = 8'(n);
        loop_size = 8'(s);
        jump      = j;
        jump_addr = 16'(ja);
        stack_clr = c;
        model_step();
        push_exp();
    endtask

    task automatic run(input int k);
        int a;
        for (int i = 0; i < k; i++) begin
            a = int'(m_addr);
            if (prog_n.exists(a)) cyc(1, 1, prog_n[a], prog_s[a], 0, 0, 0);
            else                  cyc(1, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n   = 1'b0;
        en        = 1'b0;
        loop_we   = 1'b0;
        jump      = 1'b0;
        stack_clr = 1'b0;
        m_addr    = 16'h0000;
        m_ovf     = 1'b0;
        stk.delete();
        #1;
        check("async_rst_addr", addr, 0);
        check("async_rst_depth", depth, 0);
        check("async_rst_ovf", ovf_err, 0);
        push_exp();
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            push_exp();
        end
    endtask

    task automatic set_prog(input int a, input int n, input int s);
        prog_n[a] = n;
        prog_s[a] = s;
    endtask

    // Monitor: every cycle is an output beat of the sequencer.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("addr", addr, e.addr);
                check("depth", depth, e.depth);
                check("loop_active", loop_active, e.depth != 0);
                check("ovf_err", ovf_err, e.ovf);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e, we, j, c;
        int r, ja;
        reset_n   = 1'b0;
        en        = 1'b0;
        loop_we   = 1'b0;
        loop_iter = '0;
        loop_size = '0;
        jump      = 1'b0;
        jump_addr = '0;
        stack_clr = 1'b0;
        m_addr    = '0;
        m_ovf     = 1'b0;

        // Single loop, interrupted by a reset mid-body, then rerun in full.
        do_reset(3);
        set_prog(2, 3, 2);
        run(5);
        do_reset(2);
        run(10);

        // Nested loops sharing an end address.
        prog_n.delete(); prog_s.delete();
        do_reset(1);
        set_prog(0, 2, 4);
        set_prog(1, 2, 3);
        run(17);

        // Zero-trip skip: N=0, then S=0.
        prog_n.delete(); prog_s.delete();
        cyc(1, 0, 0, 0, 1, 10, 0);
        cyc(1, 1, 0, 5, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 10, 0);
        cyc(1, 1, 4, 0, 0, 0, 0);
        run(2);

        // Stall inside a loop, then jump+flush to the top of memory and wrap.
        cyc(1, 0, 0, 0, 1, 30, 1);
        set_prog(30, 3, 3);
        run(3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2, 2, 1, 7, 1);
        run(8);
        cyc(1, 1, 2, 2, 1, 'hFFFF, 1);
        prog_n.delete(); prog_s.delete();
        run(2);

        // Five nested loops into a four-entry stack.
        cyc(1, 0, 0, 0, 1, 20, 1);
        set_prog(20, 2, 10);
        set_prog(21, 2, 8);
        set_prog(22, 2, 6);
        set_prog(23, 2, 4);
        set_prog(24, 2, 2);
        run(120);
        prog_n.delete(); prog_s.delete();

        // Randomised traffic, including loops straddling the address wrap.
        do_reset(2);
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset(1 + $urandom_range(0, 1));
            end else begin
                e  = ($urandom_range(0, 9) != 0);
                we = ($urandom_range(0, 5) == 0);
                j  = ($urandom_range(0, 29) == 0);
                c  = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 3) == 0) ja = 'hFFF8 + $urandom_range(0, 7);
                else                           ja = $urandom_range(0, 60);
                cyc(e, we, $urandom_range(0, 3), $urandom_range(0, 5), j, ja, c);
            end
        end

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
